// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared types and constants for the weight SRAM fetch engine
package weight_fetch_pkg;

    localparam int BYTES_PER_WORD  = 4;
    localparam int SRAM_ADDR_W     = 16;
    localparam int SRAM_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        EMIT,
        DONE
    } state_e;

endpackage

// File: rtl/weight_fetch.sv
// rtl/weight_fetch.sv - walks a KERNEL_H x KERNEL_W weight block out of SRAM, one byte per handshake
module weight_fetch
    import weight_fetch_pkg::*;
#(
    parameter int KERNEL_H = 3,
    parameter int KERNEL_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SRAM_ADDR_W-1:0] base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   sram_wen,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [31:0]            sram_d,
    input  logic [31:0]            sram_q,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [7:0]             w_data,
    output logic [7:0]             w_index,
    output logic                   w_last
);

    localparam int         N        = KERNEL_H * KERNEL_W;
    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    state_e                 state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]            word_q, word_d;
    logic [7:0]             idx_q, idx_d;
    logic [1:0]             byte_sel_q, byte_sel_d;

    // The SRAM is write-protected from this side.
    assign sram_wen = 1'b0;
    assign sram_d   = 32'd0;

    // The address is only driven fresh in ISSUE; otherwise the last issued one is held.
    assign sram_addr = (state_q == ISSUE) ? addr_q : sram_addr_q;

    assign busy = (state_q != IDLE);

    // State and datapath registers; reset abandons any partial kernel immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            sram_addr_q <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            byte_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            byte_sel_q  <= byte_sel_d;
        end
    end

    // Next-state and output decode for the issue/capture/emit walk.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        word_d      = word_q;
        idx_d       = idx_q;
        byte_sel_d  = byte_sel_q;
        done        = 1'b0;
        w_valid     = 1'b0;
        w_data      = 8'd0;
        w_index     = 8'd0;
        w_last      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    idx_d      = 8'd0;
                    byte_sel_d = 2'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                sram_addr_d = addr_q;
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                // Read data lands exactly one cycle after the address was presented.
                word_d     = sram_q;
                byte_sel_d = 2'd0;
                addr_d     = addr_q + SRAM_ADDR_W'(BYTES_PER_WORD);
                state_d    = EMIT;
            end
            EMIT: begin
                w_valid = 1'b1;
                w_data  = word_q[{byte_sel_q, 3'b000} +: 8];
                w_index = idx_q;
                w_last  = (idx_q == LAST_IDX);
                if (w_ready) begin
                    idx_d      = idx_q + 8'd1;
                    byte_sel_d = byte_sel_q + 2'd1;
                    // Bytes past the final weight in a partial word are dropped here.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else if (byte_sel_q == 2'd3) begin
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_weight_fetch.sv
// tb/tb_weight_fetch.sv - scoreboard bench for weight_fetch
module tb_weight_fetch;
    import weight_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem [0:65535];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 3x3 kernel
    logic        start_a, busy_a, done_a, wen_a, valid_a, ready_a, last_a;
    logic [15:0] base_a, addr_a;
    logic [31:0] d_a, q_a;
    logic [7:0]  data_a, idx_a;
    // Instance B: 1x4 kernel
    logic        start_b, busy_b, done_b, wen_b, valid_b, ready_b, last_b;
    logic [15:0] base_b, addr_b;
    logic [31:0] d_b, q_b;
    logic [7:0]  data_b, idx_b;

    weight_fetch #(.KERNEL_H(3), .KERNEL_W(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a), .busy(busy_a),
        .done(done_a), .sram_wen(wen_a), .sram_addr(addr_a), .sram_d(d_a), .sram_q(q_a),
        .w_valid(valid_a), .w_ready(ready_a), .w_data(data_a), .w_index(idx_a), .w_last(last_a)
    );

    weight_fetch #(.KERNEL_H(1), .KERNEL_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .busy(busy_b),
        .done(done_b), .sram_wen(wen_b), .sram_addr(addr_b), .sram_d(d_b), .sram_q(q_b),
        .w_valid(valid_b), .w_ready(ready_b), .w_data(data_b), .w_index(idx_b), .w_last(last_b)
    );

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        logic [15:0] a1, a2, a3;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        a3 = a + 16'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    // Registered-address SRAM models, one read port per instance
    always @(posedge clk) begin
        q_a <= rd_word(addr_a);
        q_b <= rd_word(addr_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: {valid(1), last(1), idx(8), data(8)}
    logic [17:0] exp_a[$], exp_b[$];
    logic [15:0] exp_addr_a[$], exp_addr_b[$];
    int          hs_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0, issue_cnt_b = 0;
    int          exp_done_cyc = 0;
    int          ready_mode = 0;
    logic        stall_a = 1'b0;
    logic [17:0] held_a;

    // Monitor for instance A
    always @(negedge clk) begin
        logic [17:0] cur, e;
        logic [15:0] ea;
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            cur = {valid_a, last_a, idx_a, data_a};
            if (stall_a) check("a_stall_hold", 32'(cur), 32'(held_a));
            stall_a = valid_a && !ready_a;
            held_a  = cur;
            if (valid_a && ready_a) begin
                hs_cnt_a++;
                if (exp_a.size() == 0) begin
                    check("a_unexpected_weight", 32'(cur), 32'h3FFFF);
                end else begin
                    e = exp_a.pop_front();
                    check("a_weight", 32'(cur), 32'(e));
                end
            end
            if (dut_a.state_q == ISSUE) begin
                if (exp_addr_a.size() == 0) begin
                    check("a_unexpected_read", 32'(addr_a), 32'h1FFFF);
                end else begin
                    ea = exp_addr_a.pop_front();
                    check("a_read_addr", 32'(addr_a), 32'(ea));
                end
            end
            if (done_a) begin
                done_cnt_a++;
                if (exp_done_cyc != 0) check("a_done_cycle", 32'(cyc), 32'(exp_done_cyc));
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        logic [17:0] e;
        logic [15:0] ea;
        if (!rst) begin
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_weight", {14'd0, valid_b, last_b, idx_b, data_b}, 32'h3FFFF);
                end else begin
                    e = exp_b.pop_front();
                    check("b_weight", {14'd0, valid_b, last_b, idx_b, data_b}, 32'(e));
                end
            end
            if (dut_b.state_q == ISSUE) begin
                issue_cnt_b++;
                if (exp_addr_b.size() == 0) begin
                    check("b_unexpected_read", 32'(addr_b), 32'h1FFFF);
                end else begin
                    ea = exp_addr_b.pop_front();
                    check("b_read_addr", 32'(addr_b), 32'(ea));
                end
            end
            if (done_b) done_cnt_b++;
        end
    end

    // Downstream ready for A: always high, or a 1,0,0 repeating pattern
    initial begin
        int ph;
        ph = 0;
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 3;
            ready_a = (ready_mode == 0) ? 1'b1 : (ph == 0);
        end
    end

    task automatic push_seq_a(input logic [7:0] first, input logic [15:0] base);
        for (int i = 0; i < 9; i++)
            exp_a.push_back({1'b1, (i == 8), 8'(i), 8'(first + 8'(i))});
        for (int w = 0; w < 3; w++)
            exp_addr_a.push_back(base + 16'(4 * w));
    endtask

    task automatic load_ramp(input logic [15:0] base, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++)
            mem[16'(base + 16'(i))] = 8'(first + 8'(i));
    endtask

    task automatic pulse_start_a(input logic [15:0] base);
        @(negedge clk);
        base_a  = base;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input int budget, input string name);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk);
            #2;
            if (inst == 0 && !busy_a && exp_a.size() == 0) break;
            if (inst == 1 && !busy_b && exp_b.size() == 0) break;
        end
        if (inst == 0)
            check(name, 32'(exp_a.size() + exp_addr_a.size()) + 32'(busy_a), 32'd0);
        else
            check(name, 32'(exp_b.size() + exp_addr_b.size()) + 32'(busy_b), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
        rst = 1'b1;
        start_a = 1'b0; base_a = 16'd0;
        start_b = 1'b0; base_b = 16'd0; ready_b = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs_a", {busy_a, done_a, valid_a, data_a, idx_a, last_a, wen_a, addr_a}, 32'd0);
        check("reset_sram_d_a", d_a, 32'd0);
        check("reset_outputs_b", {busy_b, done_b, valid_b, data_b, idx_b, last_b, wen_b, addr_b}, 32'd0);
        rst = 1'b0;

        // 1: ramp 1..9 from base 0, ready held high, done at t+16
        load_ramp(16'h0000, 8'd1, 9);
        push_seq_a(8'd1, 16'h0000);
        done_cnt_a = 0;
        pulse_start_a(16'h0000);
        exp_done_cyc = cyc + 15;
        wait_idle(0, 100, "t1_complete");
        check("t1_done_count", 32'(done_cnt_a), 32'd1);
        check("t1_addr_hold", 32'(addr_a), 32'h0008);
        exp_done_cyc = 0;

        // 2: same data with backpressure
        ready_mode = 1;
        push_seq_a(8'd1, 16'h0000);
        done_cnt_a = 0;
        pulse_start_a(16'h0000);
        wait_idle(0, 300, "t2_complete");
        check("t2_done_count", 32'(done_cnt_a), 32'd1);
        ready_mode = 0;

        // 3: 1x4 kernel, signed extremes, exactly one read
        mem[16'h0010] = 8'hFF; mem[16'h0011] = 8'h80;
        mem[16'h0012] = 8'h7F; mem[16'h0013] = 8'h00;
        exp_b.push_back({1'b1, 1'b0, 8'd0, 8'hFF});
        exp_b.push_back({1'b1, 1'b0, 8'd1, 8'h80});
        exp_b.push_back({1'b1, 1'b0, 8'd2, 8'h7F});
        exp_b.push_back({1'b1, 1'b1, 8'd3, 8'h00});
        exp_addr_b.push_back(16'h0010);
        @(negedge clk);
        base_b = 16'h0010; start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        wait_idle(1, 100, "t3_complete");
        check("t3_read_count", 32'(issue_cnt_b), 32'd1);
        check("t3_done_count", 32'(done_cnt_b), 32'd1);

        // 4: address wrap from 0xFFFE
        load_ramp(16'hFFFE, 8'h30, 12);
        push_seq_a(8'h30, 16'hFFFE);
        pulse_start_a(16'hFFFE);
        wait_idle(0, 100, "t4_complete");

        // 5: reset after 5 weights, then full replay
        load_ramp(16'h0000, 8'd1, 9);
        push_seq_a(8'd1, 16'h0000);
        hs_cnt_a = 0;
        pulse_start_a(16'h0000);
        for (n = 0; n < 100; n++) begin
            @(posedge clk);
            #2;
            if (hs_cnt_a >= 5) break;
        end
        check("t5_reached_5", 32'(hs_cnt_a), 32'd5);
        rst = 1'b1;
        #1;
        check("t5_reset_outputs", {busy_a, valid_a, idx_a, data_a, last_a, addr_a}, 32'd0);
        check("t5_state_idle", 32'(dut_a.state_q == IDLE), 32'd1);
        exp_a.delete();
        exp_addr_a.delete();
        @(negedge clk);
        rst = 1'b0;
        push_seq_a(8'd1, 16'h0000);
        pulse_start_a(16'h0000);
        wait_idle(0, 100, "t5_replay");

        // 6: start in EMIT and in DONE is ignored
        push_seq_a(8'd1, 16'h0000);
        hs_cnt_a = 0;
        done_cnt_a = 0;
        pulse_start_a(16'h0000);
        for (n = 0; n < 100; n++) begin
            @(posedge clk);
            #2;
            if (hs_cnt_a >= 2) break;
        end
        base_a = 16'h0200; start_a = 1'b1;
        @(posedge clk);
        #2;
        start_a = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (done_a) break;
            @(posedge clk);
            #2;
        end
        check("t6_in_done", 32'(done_a), 32'd1);
        base_a = 16'h0300; start_a = 1'b1;
        @(posedge clk);
        #2;
        start_a = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            check("t6_no_restart", 32'(busy_a), 32'd0);
        end
        check("t6_queues_empty", 32'(exp_a.size() + exp_addr_a.size()), 32'd0);
        check("t6_done_count", 32'(done_cnt_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Read-side initiator for the weight SRAM. On a start pulse it walks a KERNEL_H × KERNEL_W block of signed 8-bit weights:
- issues word reads to the SRAM, 4 bytes per word, one-cycle registered-address read latency;
- unpacks each returned 32-bit word least-significant byte first;
- streams one weight per handshake to the downstream FFT/convolution datapath.

It sits between the weight SRAM and the kernel-padding/FFT input stage.

## Interface
Parameters:
- KERNEL_H, 3, kernel rows
- KERNEL_W, 3, kernel columns; total N = KERNEL_H*KERNEL_W, 1..255

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin fetch; sampled only in IDLE
- base_addr  in  16  byte address of weight 0; latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final weight handshake
- sram_wen  out  1  tied 0
- sram_addr  out  16  SRAM byte address
- sram_d  out  32  tied 0
- sram_q  in  32  SRAM read data, valid the cycle after sram_addr was sampled
- w_valid  out  1  weight available
- w_ready  in  1  downstream accepts
- w_data  out  8  signed weight
- w_index  out  8  weight ordinal 0..N-1 (row-major)
- w_last  out  1  high with index N-1

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, EMIT, DONE.
- IDLE:
  - start=1 latches base_addr into addr_r, clears idx and byte_sel, and moves to ISSUE.
  - start=0 stays in IDLE.
- ISSUE: drives sram_addr=addr_r, then moves to CAPTURE.
- CAPTURE:
  - latches sram_q into word_r and sets byte_sel=0;
  - addr_r += 4, wrapping modulo 2^16;
  - moves to EMIT.
- EMIT:
  - w_valid=1 and w_data=word_r[8*byte_sel+:8];
  - w_index=idx and w_last=(idx==N-1);
  - on w_valid&&w_ready, idx and byte_sel increment;
  - the transfer of idx==N-1 moves to DONE;
  - otherwise the transfer with byte_sel==3 moves to ISSUE;
  - otherwise the FSM stays in EMIT.
- DONE: asserts done for one cycle, then moves to IDLE.
- Partial last word (N mod 4 ≠ 0): unused upper bytes are read but discarded.
- base_addr needs no word alignment. The SRAM assembles bytes addr..addr+3.
- No arithmetic is performed on the weights. w_data is the raw byte; signedness is for the consumer.

## Timing
- Reset values:
  - busy=0, done=0, w_valid=0, w_data=0, w_index=0, w_last=0;
  - sram_addr=0, sram_wen=0, sram_d=0;
  - FSM in IDLE, all internal registers 0.
- Start accepted at edge t → ISSUE during cycle t+1, CAPTURE during t+2, first w_valid in cycle t+3.
- With w_ready held high, each word costs 6 cycles (ISSUE, CAPTURE, 4× EMIT). N=9 therefore finishes its last handshake in cycle t+15 and pulses done in t+16. busy falls in t+17.
- sram_addr holds its last issued value outside ISSUE. It returns to 0 only on reset.
- Backpressure: while w_valid && !w_ready, w_data, w_index and w_last stay stable and no SRAM read is issued.
- start outside IDLE (including in DONE) is ignored, and base_addr is not re-latched.
- Reset mid-fetch takes effect immediately (asynchronous). All outputs return to their reset values, and a partially delivered kernel is abandoned.
- Address wrap: base 0xFFFE gives a second read at 0x0002.

## Structure
- Shared package weight_fetch_pkg holds:
  - the state enum (IDLE, ISSUE, CAPTURE, EMIT, DONE);
  - BYTES_PER_WORD=4 and SRAM_ADDR_W=16;
  - SRAM_RD_LATENCY=1.
- Single module, no sub-modules. The byte unpack is one indexed part-select and does not justify its own block.

## Test plan
- SRAM bytes 0..8 = 1..9, base 0, w_ready=1 → sram_addr 0,4,8 issued:
  - w_data 1..9 with w_index 0..8;
  - w_last only on 9;
  - done pulses once at t+16.
- Same data with w_ready toggling 1,0,0,1,… → identical sequence with no duplicates or drops, and outputs stable while stalled.
- Bytes 0xFF,0x80,0x7F,0x00 at base 0x0010, KERNEL_H=1, KERNEL_W=4 → w_data −1, −128, 127, 0 and exactly one SRAM read.
- base 0xFFFE, N=9 → reads at 0xFFFE, 0x0002, 0x0006, and 9 weights delivered.
- rst asserted in EMIT after 5 weights → next cycle w_valid=0, busy=0, FSM IDLE. A new start replays from w_index 0.
- start pulsed in EMIT and in DONE with a different base_addr → ignored, and the original sequence completes unchanged.
